// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: size codes, FSM states,
// the EX/MEM latch bundle and byte-lane helpers.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  size;
        logic        lsigned;
    } ex_mem_t;

    function automatic logic [3:0] lane_be(
        input logic [1:0] a,
        input logic [1:0] sz
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            (sz == SZ_BYTE): be = 4'b0001 << a;
            (sz == SZ_HALF): be = a[1] ? 4'b1100 : 4'b0011;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    // Reserved size 2'b11 behaves as a word.
    function automatic logic is_aligned(
        input logic [1:0] a,
        input logic [1:0] sz
    );
        logic ok;
        ok = 1'b1;
        unique case (1'b1)
            (sz == SZ_BYTE): ok = 1'b1;
            (sz == SZ_HALF): ok = ~a[0];
            default:         ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data RAM/IO request bus between the memory stage (master)
// and the memory or IO fabric (slave).
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load
// lane extraction with sign or zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic        is_byte;
    logic        is_half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_byte = (size_i == SZ_BYTE);
    assign is_half = (size_i == SZ_HALF);
    assign ld_byte = 8'(ld_raw_i >> {addr_lo_i, 3'b000});
    assign ld_half = addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    assign be_o    = lane_be(addr_lo_i, size_i);

    always_comb begin
        wdata_o   = st_data_i;
        ld_data_o = ld_raw_i;
        unique case (1'b1)
            is_byte: begin
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{signed_i & ld_byte[7]}}, ld_byte};
            end
            is_half: begin
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = {{16{signed_i & ld_half[15]}}, ld_half};
            end
            default: begin
                wdata_o   = st_data_i;
                ld_data_o = ld_raw_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM latch, load/store handshake
// with timeout, alignment faults and the MEM/WB latch.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rt_value,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_load_signed,
    mem_stage_if.master mem,
    output logic        stall,
    output logic [31:0] fwd_result,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] bad_vaddr
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_e      state_q;
    ex_mem_t     op_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic        wb_valid_q;
    logic        wb_reg_write_q;
    logic [4:0]  wb_waddr_q;
    logic [31:0] wb_data_q;
    logic        addr_err_q;
    logic        bus_err_q;
    logic [31:0] bad_vaddr_q;

    logic        access;
    logic        ex_is_mem;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld;

    mem_lane_align u_align (
        .addr_lo_i (op_q.alu[1:0]),
        .size_i    (op_q.size),
        .signed_i  (op_q.lsigned),
        .st_data_i (op_q.rt),
        .ld_raw_i  (mem.mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld)
    );

    assign access    = (state_q == ST_ACCESS);
    assign ex_is_mem = ex_mem_read | ex_mem_write;
    assign cnt_d     = cnt_q + CW'(1);

    // Bus outputs come straight off the state flop, so an async
    // reset drops the request without waiting for a clock edge.
    assign mem.mem_req   = access;
    assign mem.mem_we    = access & op_q.mem_write;
    assign mem.mem_addr  = access ? {op_q.alu[31:2], 2'b00} : RESET_DATA;
    assign mem.mem_be    = access ? al_be : 4'b0000;
    assign mem.mem_wdata = access ? al_wdata : RESET_DATA;

    assign stall        = access;
    assign fwd_result   = op_q.alu;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_waddr     = wb_waddr_q;
    assign wb_data      = wb_data_q;
    assign addr_err     = addr_err_q;
    assign bus_err      = bus_err_q;
    assign bad_vaddr    = bad_vaddr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            op_q.alu       <= RESET_DATA;
            op_q.rt        <= RESET_DATA;
            cnt_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_waddr_q     <= 5'd0;
            wb_data_q      <= RESET_DATA;
            addr_err_q     <= 1'b0;
            bus_err_q      <= 1'b0;
            bad_vaddr_q    <= RESET_DATA;
        end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            addr_err_q     <= 1'b0;
            bus_err_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        op_q.alu       <= ex_alu_result;
                        op_q.rt        <= ex_rt_value;
                        op_q.reg_write <= ex_reg_write;
                        op_q.mem_write <= ex_mem_write;
                        op_q.size      <= ex_mem_size;
                        op_q.lsigned   <= ex_load_signed;
                        wb_waddr_q     <= ex_waddr;
                        if (!ex_is_mem) begin
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= ex_reg_write;
                            wb_data_q      <= ex_alu_result;
                        end else if (!is_aligned(ex_alu_result[1:0],
                                                 ex_mem_size)) begin
                            addr_err_q  <= 1'b1;
                            bad_vaddr_q <= ex_alu_result;
                            wb_valid_q  <= 1'b1;
                            wb_data_q   <= ex_alu_result;
                        end else begin
                            state_q <= ST_ACCESS;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ready wins over a timeout landing on the same cycle.
                    if (mem.mem_ready) begin
                        state_q        <= ST_DRAIN;
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= op_q.reg_write & ~op_q.mem_write;
                        wb_data_q      <= op_q.mem_write ? op_q.alu : al_ld;
                    end else if (cnt_q == LAST) begin
                        state_q     <= ST_DRAIN;
                        bus_err_q   <= 1'b1;
                        bad_vaddr_q <= op_q.alu;
                        wb_valid_q  <= 1'b1;
                        wb_data_q   <= op_q.alu;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expectations,
// negedge monitors pop and compare what the stage presents.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] data;
        logic        cd;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        kind;
        logic [31:0] vaddr;
    } err_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_rt_value = '0;
    logic [4:0]  ex_waddr = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [1:0]  ex_mem_size = 2'b00;
    logic        ex_load_signed = 1'b0;
    logic        stall;
    logic [31:0] fwd_result;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic        addr_err;
    logic        bus_err;
    logic [31:0] bad_vaddr;

    int total = 0;
    int bad = 0;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    err_t err_q[$];
    int   stall_q[$];

    int          rdy_delay = 0;
    logic [31:0] rd_val = '0;
    int          wcnt = 0;

    always #5 clock = ~clock;

    mem_stage_if mif();

    mem_stage #(
        .TIMEOUT    (TO),
        .RESET_DATA (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_rt_value    (ex_rt_value),
        .ex_waddr       (ex_waddr),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_size    (ex_mem_size),
        .ex_load_signed (ex_load_signed),
        .mem            (mif),
        .stall          (stall),
        .fwd_result     (fwd_result),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_waddr       (wb_waddr),
        .wb_data        (wb_data),
        .addr_err       (addr_err),
        .bus_err        (bus_err),
        .bad_vaddr      (bad_vaddr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        total++;
        bad++;
        $display("FAIL %s: output seen with nothing expected", name);
    endtask

    // Memory responder: ready after rdy_delay low cycles of a request.
    always @(negedge clock) begin
        mif.mem_rdata = rd_val;
        if (reset || !mif.mem_req) begin
            mif.mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            mif.mem_ready = (wcnt == rdy_delay);
            wcnt++;
        end
    end

    always @(negedge clock) begin
        wb_t e;
        if (!reset && wb_valid) begin
            if (wb_q.size() == 0) begin
                miss("wb_unexpected");
            end else begin
                e = wb_q.pop_front();
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("wb_waddr", 32'(wb_waddr), 32'(e.wa));
                if (e.cd) chk("wb_data", wb_data, e.data);
            end
        end
    end

    logic req_prev = 1'b0;
    always @(negedge clock) begin
        bus_t b;
        if (reset) begin
            req_prev = 1'b0;
        end else begin
            if (mif.mem_req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    miss("mem_req_unexpected");
                end else begin
                    b = bus_q.pop_front();
                    chk("mem_we", 32'(mif.mem_we), 32'(b.we));
                    chk("mem_addr", mif.mem_addr, b.addr);
                    if (b.we) begin
                        chk("mem_be", 32'(mif.mem_be), 32'(b.be));
                        chk("mem_wdata", mif.mem_wdata, b.wdata);
                    end
                end
            end
            req_prev = mif.mem_req;
        end
    end

    always @(negedge clock) begin
        err_t e;
        if (!reset && (addr_err || bus_err)) begin
            if (err_q.size() == 0) begin
                miss("err_unexpected");
            end else begin
                e = err_q.pop_front();
                chk("err_kind_bus", 32'(bus_err), 32'(e.kind));
                chk("err_kind_addr", 32'(addr_err), 32'(!e.kind));
                chk("bad_vaddr", bad_vaddr, e.vaddr);
                if (bus_err) chk("buserr_req_drop", 32'(mif.mem_req), 32'd0);
            end
        end
    end

    int  srun = 0;
    logic sprev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            srun = 0;
            sprev = 1'b0;
        end else begin
            if (stall) begin
                srun++;
            end else if (sprev) begin
                if (stall_q.size() == 0) miss("stall_unexpected");
                else chk("stall_cycles", 32'(srun), 32'(stall_q.pop_front()));
                srun = 0;
            end
            sprev = stall;
        end
    end

    task automatic exp_wb(input logic rw, input logic [4:0] wa,
                          input logic [31:0] d, input logic cd);
        wb_t e;
        e.rw = rw; e.wa = wa; e.data = d; e.cd = cd;
        wb_q.push_back(e);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        bus_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic exp_err(input logic k, input logic [31:0] a);
        err_t e;
        e.kind = k; e.vaddr = a;
        err_q.push_back(e);
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sgn,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] wa, input logic rw);
        ex_valid = 1'b1;
        ex_mem_read = rd;
        ex_mem_write = wr;
        ex_mem_size = sz;
        ex_load_signed = sgn;
        ex_alu_result = alu;
        ex_rt_value = rt;
        ex_waddr = wa;
        ex_reg_write = rw;
        @(negedge clock);
        ex_valid = 1'b0;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sgn,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] wa, input logic rw);
        bit done;
        done = 1'b0;
        drive(rd, wr, sz, sgn, alu, rt, wa, rw);
        for (int i = 0; i < 64; i++) begin
            if (!stall) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("stall_release", 32'(done), 32'd1);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
        chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
        chk("rst_mem_be", 32'(mif.mem_be), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_waddr", 32'(wb_waddr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_errs", 32'({addr_err, bus_err}), 32'd0);
        chk("rst_bad_vaddr", bad_vaddr, 32'd0);
        chk("rst_fwd", fwd_result, 32'd0);
        @(negedge clock);

        // plain ALU op
        exp_wb(1'b1, 5'd5, 32'h1234_5678, 1'b1);
        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
        chk("alu_fwd", fwd_result, 32'h1234_5678);

        // lb / lbu, ready after 3 low cycles
        rdy_delay = 3; rd_val = 32'h80FF_FFFF;
        exp_bus(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        stall_q.push_back(4);
        exp_wb(1'b1, 5'd3, 32'hFFFF_FF80, 1'b1);
        issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0, 5'd3, 1'b1);
        exp_bus(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        stall_q.push_back(4);
        exp_wb(1'b1, 5'd4, 32'h0000_0080, 1'b1);
        issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0, 5'd4, 1'b1);

        // sh upper half
        rdy_delay = 0;
        exp_bus(1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
        stall_q.push_back(1);
        exp_wb(1'b0, 5'd6, 32'h0, 1'b0);
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF,
              5'd6, 1'b0);

        // misaligned lw
        exp_err(1'b0, 32'h0000_0006);
        exp_wb(1'b0, 5'd7, 32'h0, 1'b0);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0, 5'd7, 1'b1);

        // lw timeout
        rdy_delay = 1000;
        exp_bus(1'b0, 32'h0000_0700, 4'h0, 32'h0);
        stall_q.push_back(TO);
        exp_err(1'b1, 32'h0000_0700);
        exp_wb(1'b0, 5'd8, 32'h0, 1'b0);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0700, 32'h0, 5'd8, 1'b1);

        // ready on the last timeout cycle: ready wins
        rdy_delay = TO - 1; rd_val = 32'hCAFE_0001;
        exp_bus(1'b0, 32'h0000_0710, 4'h0, 32'h0);
        stall_q.push_back(TO);
        exp_wb(1'b1, 5'd9, 32'hCAFE_0001, 1'b1);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0710, 32'h0, 5'd9, 1'b1);

        // lh signed upper lane
        rdy_delay = 1; rd_val = 32'h8001_1234;
        exp_bus(1'b0, 32'h0000_0400, 4'h0, 32'h0);
        stall_q.push_back(2);
        exp_wb(1'b1, 5'd10, 32'hFFFF_8001, 1'b1);
        issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0402, 32'h0, 5'd10, 1'b1);

        // lhu lower lane
        rdy_delay = 0; rd_val = 32'h8001_F00D;
        exp_bus(1'b0, 32'h0000_0400, 4'h0, 32'h0);
        stall_q.push_back(1);
        exp_wb(1'b1, 5'd11, 32'h0000_F00D, 1'b1);
        issue(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0400, 32'h0, 5'd11, 1'b1);

        // sb lane 1
        rdy_delay = 2;
        exp_bus(1'b1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5);
        stall_q.push_back(3);
        exp_wb(1'b0, 5'd12, 32'h0, 1'b0);
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0301, 32'h1234_56A5,
              5'd12, 1'b0);

        // sw
        rdy_delay = 0;
        exp_bus(1'b1, 32'h0000_0804, 4'b1111, 32'h1122_3344);
        stall_q.push_back(1);
        exp_wb(1'b0, 5'd13, 32'h0, 1'b0);
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0804, 32'h1122_3344,
              5'd13, 1'b0);

        // lb positive byte, lane 1
        rd_val = 32'h0000_7F00;
        exp_bus(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        stall_q.push_back(1);
        exp_wb(1'b1, 5'd14, 32'h0000_007F, 1'b1);
        issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0101, 32'h0, 5'd14, 1'b1);

        // reserved size code acts as word
        rd_val = 32'h1357_9BDF;
        exp_bus(1'b0, 32'h0000_0900, 4'h0, 32'h0);
        stall_q.push_back(1);
        exp_wb(1'b1, 5'd15, 32'h1357_9BDF, 1'b1);
        issue(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0900, 32'h0, 5'd15, 1'b1);

        // misaligned sh
        exp_err(1'b0, 32'h0000_0203);
        exp_wb(1'b0, 5'd16, 32'h0, 1'b0);
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0203, 32'h0, 5'd16, 1'b0);

        // reset in the middle of an access
        rdy_delay = 1000;
        exp_bus(1'b0, 32'h0000_0A00, 4'h0, 32'h0);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0A00, 32'h0, 5'd17, 1'b1);
        chk("pre_rst_req", 32'(mif.mem_req), 32'd1);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("access_fwd", fwd_result, 32'h0000_0A00);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(mif.mem_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_rst_bad_vaddr", bad_vaddr, 32'd0);
        chk("post_rst_fwd", fwd_result, 32'd0);
        @(negedge clock);

        // a fresh lw completes normally after reset
        rdy_delay = 0; rd_val = 32'hDEAD_BEEF;
        exp_bus(1'b0, 32'h0000_0804, 4'h0, 32'h0);
        stall_q.push_back(1);
        exp_wb(1'b1, 5'd18, 32'hDEAD_BEEF, 1'b1);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0804, 32'h0, 5'd18, 1'b1);

        repeat (4) @(negedge clock);
        chk("wb_q_left", 32'(wb_q.size()), 32'd0);
        chk("bus_q_left", 32'(bus_q.size()), 32'd0);
        chk("err_q_left", 32'(err_q.size()), 32'd0);
        chk("stall_q_left", 32'(stall_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
